// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - control word bundle passed from memory stage to writeback
interface rvga_cword_if;
  logic       rd_w_v;
  logic       dcache_r_v;
  logic [2:0] ldop;

  modport master (output rd_w_v, dcache_r_v, ldop);
  modport slave  (input  rd_w_v, dcache_r_v, ldop);
  modport i      (input  rd_w_v, dcache_r_v, ldop);
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - load formatting, registered RF write port, instret and misalign halt
// ldop uses the RISC-V funct3 load encoding (LB=0, LH=1, LW=2, LBU=4, LHU=5).
module writeback_stage #(
  parameter int INSTRET_W        = 64,
  parameter bit HALT_ON_MISALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memory_writeback_v,
  input  logic [4:0]           memory_writeback_rd,
  input  logic [31:0]          memory_writeback_result,
  input  logic [1:0]           memory_writeback_addr_lo,
  rvga_cword_if.i              cword_i,
  input  logic                 halt_clear_i,
  output logic                 rf_w_en_o,
  output logic [4:0]           rf_w_addr_o,
  output logic [31:0]          rf_w_data_o,
  output logic                 fwd_v_o,
  output logic [4:0]           fwd_rd_o,
  output logic [31:0]          fwd_data_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 misalign_o,
  output logic                 halted_o
);

  localparam logic [2:0] LDOP_LB  = 3'd0;
  localparam logic [2:0] LDOP_LH  = 3'd1;
  localparam logic [2:0] LDOP_LBU = 3'd4;
  localparam logic [2:0] LDOP_LHU = 3'd5;

  typedef enum logic {S_RUN, S_HALTED} state_t;
  state_t state_q, state_d;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] wb_data;
  logic        ld_misal;
  logic        accept, is_mis, retire, do_write;

  always_comb begin
    ld_byte  = memory_writeback_result[7:0];
    ld_half  = memory_writeback_addr_lo[1] ? memory_writeback_result[31:16]
                                           : memory_writeback_result[15:0];
    wb_data  = memory_writeback_result;
    ld_misal = 1'b0;
    case (memory_writeback_addr_lo)
      2'd0:    ld_byte = memory_writeback_result[7:0];
      2'd1:    ld_byte = memory_writeback_result[15:8];
      2'd2:    ld_byte = memory_writeback_result[23:16];
      default: ld_byte = memory_writeback_result[31:24];
    endcase
    if (cword_i.dcache_r_v) begin
      case (cword_i.ldop)
        LDOP_LB:  wb_data = {{24{ld_byte[7]}}, ld_byte};
        LDOP_LBU: wb_data = {24'd0, ld_byte};
        LDOP_LH: begin
          wb_data  = {{16{ld_half[15]}}, ld_half};
          ld_misal = memory_writeback_addr_lo[0];
        end
        LDOP_LHU: begin
          wb_data  = {16'd0, ld_half};
          ld_misal = memory_writeback_addr_lo[0];
        end
        default: begin
          wb_data  = memory_writeback_result;
          ld_misal = (memory_writeback_addr_lo != 2'd0);
        end
      endcase
    end
  end

  assign accept   = memory_writeback_v && (state_q == S_RUN);
  assign is_mis   = accept && ld_misal;
  assign retire   = accept && !ld_misal;
  assign do_write = retire && cword_i.rd_w_v && (memory_writeback_rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RUN;
    else      state_q <= state_d;
  end

  // Inputs presented while HALTED (including the clear cycle) are never accepted.
  always_comb begin
    state_d  = state_q;
    halted_o = 1'b0;
    case (state_q)
      S_RUN:
        if (is_mis && HALT_ON_MISALIGN) state_d = S_HALTED;
      default: begin
        halted_o = 1'b1;
        if (halt_clear_i) state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_w_en_o   <= 1'b0;
      rf_w_addr_o <= 5'd0;
      rf_w_data_o <= 32'd0;
      instret_o   <= '0;
      misalign_o  <= 1'b0;
    end else begin
      rf_w_en_o  <= do_write;
      misalign_o <= is_mis;
      if (do_write) begin
        rf_w_addr_o <= memory_writeback_rd;
        rf_w_data_o <= wb_data;
      end
      if (retire) instret_o <= instret_o + INSTRET_W'(1);
    end
  end

  assign fwd_v_o    = rf_w_en_o;
  assign fwd_rd_o   = rf_w_addr_o;
  assign fwd_data_o = rf_w_data_o;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - table, directed and random checks of writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        v = 1'b0, clr = 1'b0, rdw = 1'b0, dc = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] res = '0;
  logic [1:0]  lo = '0;
  logic [2:0]  op = '0;

  logic        en0, fv0, mis0, hlt0, en1, fv1, mis1, hlt1;
  logic [4:0]  a0, fr0, a1, fr1;
  logic [31:0] d0, fd0, d1, fd1;
  logic [63:0] ir0;
  logic [3:0]  ir1;

  int checks = 0;
  int errors = 0;

  rvga_cword_if cw0 ();
  rvga_cword_if cw1 ();
  assign cw0.rd_w_v = rdw;  assign cw0.dcache_r_v = dc;  assign cw0.ldop = op;
  assign cw1.rd_w_v = rdw;  assign cw1.dcache_r_v = dc;  assign cw1.ldop = op;

  writeback_stage #(.INSTRET_W(64), .HALT_ON_MISALIGN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .memory_writeback_v(v), .memory_writeback_rd(rd),
    .memory_writeback_result(res), .memory_writeback_addr_lo(lo), .cword_i(cw0),
    .halt_clear_i(clr), .rf_w_en_o(en0), .rf_w_addr_o(a0), .rf_w_data_o(d0),
    .fwd_v_o(fv0), .fwd_rd_o(fr0), .fwd_data_o(fd0), .instret_o(ir0),
    .misalign_o(mis0), .halted_o(hlt0));

  writeback_stage #(.INSTRET_W(4), .HALT_ON_MISALIGN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .memory_writeback_v(v), .memory_writeback_rd(rd),
    .memory_writeback_result(res), .memory_writeback_addr_lo(lo), .cword_i(cw1),
    .halt_clear_i(clr), .rf_w_en_o(en1), .rf_w_addr_o(a1), .rf_w_data_o(d1),
    .fwd_v_o(fv1), .fwd_rd_o(fr1), .fwd_data_o(fd1), .instret_o(ir1),
    .misalign_o(mis1), .halted_o(hlt1));

  always #5 clk = ~clk;

  // Reference model: index 0 halts on misalign with a 64-bit counter, index 1 flags only with 4 bits.
  bit          m_halt_en [2] = '{1'b1, 1'b0};
  logic [63:0] m_mask    [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hF};
  bit          mh [2], men [2], mm [2];
  logic [63:0] mi [2];
  logic [4:0]  ma [2];
  logic [31:0] md [2];

  function automatic logic [31:0] load_fmt(logic [2:0] o, logic [31:0] r, logic [1:0] l);
    logic [31:0] s;
    byte         sb;
    shortint     sh;
    s  = r >> (8 * int'(l));
    sb = byte'(s[7:0]);
    sh = shortint'(s[15:0]);
    case (o)
      3'd0:    return 32'(int'(sb));
      3'd4:    return s & 32'hFF;
      3'd1:    return 32'(int'(sh));
      3'd5:    return s & 32'hFFFF;
      default: return r;
    endcase
  endfunction

  function automatic int load_size(logic [2:0] o);
    if (o == 3'd0 || o == 3'd4) return 1;
    if (o == 3'd1 || o == 3'd5) return 2;
    return 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; men[k] = 0; mm[k] = 0; mi[k] = '0; ma[k] = '0; md[k] = '0;
    end
  endtask

  task automatic model_clock();
    bit misaligned;
    for (int k = 0; k < 2; k++) begin
      men[k] = 0;
      mm[k]  = 0;
      if (mh[k]) begin
        if (clr) mh[k] = 0;
      end else if (v) begin
        misaligned = dc && ((int'(lo) % load_size(op)) != 0);
        if (misaligned) begin
          mm[k] = 1;
          if (m_halt_en[k]) mh[k] = 1;
        end else begin
          mi[k] = (mi[k] + 64'd1) & m_mask[k];
          if (rdw && rd != 5'd0) begin
            men[k] = 1;
            ma[k]  = rd;
            md[k]  = dc ? load_fmt(op, res, lo) : res;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("en0", 64'(en0), 64'(men[0]));     chk("fwd_v0", 64'(fv0), 64'(men[0]));
    chk("addr0", 64'(a0), 64'(ma[0]));     chk("fwd_rd0", 64'(fr0), 64'(ma[0]));
    chk("data0", 64'(d0), 64'(md[0]));     chk("fwd_data0", 64'(fd0), 64'(md[0]));
    chk("instret0", ir0, mi[0]);           chk("mis0", 64'(mis0), 64'(mm[0]));
    chk("halted0", 64'(hlt0), 64'(mh[0]));
    chk("en1", 64'(en1), 64'(men[1]));     chk("fwd_v1", 64'(fv1), 64'(men[1]));
    chk("addr1", 64'(a1), 64'(ma[1]));     chk("data1", 64'(d1), 64'(md[1]));
    chk("fwd_data1", 64'(fd1), 64'(md[1]));
    chk("instret1", 64'(ir1), mi[1]);      chk("mis1", 64'(mis1), 64'(mm[1]));
    chk("halted1", 64'(hlt1), 64'(mh[1]));
  endtask

  task automatic step(input logic iv, input logic [4:0] ird, input logic [31:0] ires,
                      input logic [1:0] ilo, input logic irdw, input logic idc,
                      input logic [2:0] iop, input logic iclr);
    v = iv; rd = ird; res = ires; lo = ilo; rdw = irdw; dc = idc; op = iop; clr = iclr;
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    v = 0; clr = 0;
    rst = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        dc;
    logic        rdw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [1:0]  lo;
    logic        een;
    logic [31:0] edata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [63:0] saved;
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    tbl[0] = '{3'd0, 1, 1, 5'd5,  32'h8070_6050, 2'd3, 1, 32'hFFFF_FF80};
    tbl[1] = '{3'd4, 1, 1, 5'd5,  32'h8070_6050, 2'd3, 1, 32'h0000_0080};
    tbl[2] = '{3'd1, 1, 1, 5'd6,  32'h1234_ABCD, 2'd0, 1, 32'hFFFF_ABCD};
    tbl[3] = '{3'd5, 1, 1, 5'd7,  32'h1234_ABCD, 2'd2, 1, 32'h0000_1234};
    tbl[4] = '{3'd0, 0, 1, 5'd0,  32'hDEAD_BEEF, 2'd0, 0, 32'h0};
    tbl[5] = '{3'd0, 0, 1, 5'd9,  32'hDEAD_BEEF, 2'd1, 1, 32'hDEAD_BEEF};
    tbl[6] = '{3'd2, 1, 1, 5'd10, 32'h0BAD_F00D, 2'd0, 1, 32'h0BAD_F00D};
    tbl[7] = '{3'd0, 1, 1, 5'd11, 32'h0000_7F00, 2'd1, 1, 32'h0000_007F};
    tbl[8] = '{3'd2, 0, 0, 5'd3,  32'h1111_2222, 2'd3, 0, 32'h0};

    do_reset();
    chk("reset_en", 64'(en0), 64'd0);
    chk("reset_instret", ir0, 64'd0);

    for (int i = 0; i < 9; i++) begin
      saved = ir0;
      step(1, tbl[i].rd, tbl[i].res, tbl[i].lo, tbl[i].rdw, tbl[i].dc, tbl[i].op, 0);
      chk($sformatf("tbl%0d_en", i), 64'(en0), 64'(tbl[i].een));
      if (tbl[i].een) begin
        chk($sformatf("tbl%0d_addr", i), 64'(a0), 64'(tbl[i].rd));
        chk($sformatf("tbl%0d_data", i), 64'(d0), 64'(tbl[i].edata));
      end
      chk($sformatf("tbl%0d_instret", i), ir0, saved + 64'd1);
    end

    // Misaligned LW halts; valid ops are dropped until the clear.
    saved = ir0;
    step(1, 5'd4, 32'hCAFE_0000, 2'd2, 1, 1, 3'd2, 0);
    chk("halt_mis_pulse", 64'(mis0), 64'd1);
    chk("halt_no_write", 64'(en0), 64'd0);
    chk("halt_halted", 64'(hlt0), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1, 5'(i), 32'h100 + 32'(i), 2'd0, 1, 0, 3'd0, 0);
      chk("halted_no_write", 64'(en0), 64'd0);
      chk("halted_instret", ir0, saved);
      chk("halted_mis_once", 64'(mis0), 64'd0);
    end
    step(1, 5'd12, 32'h5555_5555, 2'd0, 1, 0, 3'd0, 1);
    chk("clear_halted", 64'(hlt0), 64'd0);
    chk("clear_dropped", 64'(en0), 64'd0);
    step(1, 5'd8, 32'h0000_ABBA, 2'd0, 1, 0, 3'd0, 0);
    chk("after_clear_en", 64'(en0), 64'd1);
    chk("after_clear_addr", 64'(a0), 64'd8);
    step(0, 5'd9, 32'h0, 2'd0, 1, 0, 3'd0, 1);
    chk("clear_in_run_ignored", 64'(hlt0), 64'd0);
    chk("hold_data", 64'(d0), 64'h0000_ABBA);

    // 4-bit counter wraps on the 16th retire.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 5'd1, 32'(i), 2'd0, 1, 0, 3'd0, 0);
    chk("wrap_15", 64'(ir1), 64'd15);
    step(1, 5'd1, 32'h77, 2'd0, 1, 0, 3'd0, 0);
    chk("wrap_0", 64'(ir1), 64'd0);

    // Asynchronous reset in the middle of a write cycle.
    step(1, 5'd20, 32'h1357_9BDF, 2'd0, 1, 0, 3'd0, 0);
    chk("pre_async_en", 64'(en0), 64'd1);
    #3;
    rst = 0;
    #1;
    model_reset();
    check_all();
    chk("async_en", 64'(en0), 64'd0);
    chk("async_data", 64'(d0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1;

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0,
           ($urandom % 6 == 0) ? 5'd0 : 5'($urandom),
           $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
           ops[$urandom % 5], ($urandom % 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
